// File: rtl/relay_frame_detect.sv
// Relay framing engine: deglitches the relay link, samples it at the sub-carrier
// bit rate, tracks start/end patterns per role and drives the front-end mod_type.
module relay_frame_detect #(
   parameter int unsigned FILT_LEN     = 8,
   parameter int unsigned SAMPLE_DIV   = 16,
   parameter int unsigned SAMPLE_PHASE = 8,
   parameter logic [7:0]  RD_START     = 8'hc0,
   parameter logic [15:0] RD_END_A     = 16'h0000,
   parameter logic [15:0] RD_END_B     = 16'hc000,
   parameter logic [7:0]  TG_START     = 8'hf0,
   parameter logic [15:0] TG_END       = 16'h0000,
   parameter int unsigned MAX_BITS     = 4096,
   parameter int unsigned DELAY_TAP    = 7
) (
   input  logic       ck_1356meg,
   input  logic       rst,
   input  logic       enable,
   input  logic       is_tag,
   input  logic       dbg,
   output logic [2:0] mod_type,
   output logic       frame_active,
   output logic       bit_strobe,
   output logic       bit_out,
   output logic [7:0] frame_count,
   output logic       timeout_err
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int CNT_W = $clog2(FILT_LEN + 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_PHASE = DIV_W'(SAMPLE_PHASE);
   localparam logic [CNT_W-1:0] HALF      = CNT_W'(FILT_LEN / 2);
   localparam logic [15:0]      BT_LAST   = 16'(MAX_BITS - 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t                state_reg, state_next;
   logic [FILT_LEN-1:0]   filt_reg;
   logic [DIV_W-1:0]      div_reg, div_next;
   logic [23:0]           sr_reg, sr_next;
   logic [2:0]            bc_reg, bc_next;
   logic [15:0]           bt_reg, bt_next;
   logic [7:0]            fc_reg, fc_next;
   logic                  strobe_reg;
   logic                  tout_reg, tout_next;

   logic [CNT_W-1:0]      ones;
   logic                  fbit;
   logic                  strobe;
   logic [23:0]           sr_n;
   logic [2:0]            bc_n;
   logic                  start_hit;
   logic                  end_hit;

   // The filter keeps running while disabled so it is settled on re-enable.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         filt_reg <= '0;
      end else begin
         filt_reg <= {filt_reg[FILT_LEN-2:0], dbg};
      end
   end

   always_comb begin
      ones = '0;
      for (int i = 0; i < int'(FILT_LEN); i++) begin
         ones = ones + CNT_W'(filt_reg[i]);
      end
   end

   assign fbit   = (ones >= HALF);
   assign strobe = enable && (div_reg == DIV_PHASE);
   assign sr_n   = {sr_reg[22:0], fbit};
   assign bc_n   = bc_reg + 3'd1;

   always_comb begin
      start_hit = is_tag ? (sr_n == {16'h0000, TG_START}) : (sr_n == {16'h0000, RD_START});
      end_hit   = 1'b0;
      if (bc_n == 3'd0 && sr_n[7:0] == 8'h00) begin
         end_hit = is_tag ? (sr_n[23:8] == TG_END)
                          : (sr_n[23:8] == RD_END_A || sr_n[23:8] == RD_END_B);
      end
   end

   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         state_reg  <= IDLE;
         div_reg    <= '0;
         sr_reg     <= '0;
         bc_reg     <= '0;
         bt_reg     <= '0;
         fc_reg     <= '0;
         strobe_reg <= 1'b0;
         tout_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         div_reg    <= div_next;
         sr_reg     <= sr_next;
         bc_reg     <= bc_next;
         bt_reg     <= bt_next;
         fc_reg     <= fc_next;
         strobe_reg <= strobe;
         tout_reg   <= tout_next;
      end
   end

   // Start realigns even mid-frame; end beats timeout; only end counts a frame.
   always_comb begin
      state_next = state_reg;
      div_next   = div_reg;
      sr_next    = sr_reg;
      bc_next    = bc_reg;
      bt_next    = bt_reg;
      fc_next    = fc_reg;
      tout_next  = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         div_next   = '0;
         sr_next    = '0;
         bc_next    = '0;
         bt_next    = '0;
      end else begin
         div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
         if (strobe) begin
            sr_next = sr_n;
            bc_next = bc_n;
            if (start_hit) begin
               state_next = ACTIVE;
               bc_next    = '0;
               bt_next    = '0;
            end else if (state_reg == ACTIVE) begin
               if (end_hit) begin
                  state_next = IDLE;
                  fc_next    = fc_reg + 8'd1;
               end else if (bt_reg == BT_LAST) begin
                  state_next = IDLE;
                  tout_next  = 1'b1;
               end else begin
                  bt_next = bt_reg + 16'd1;
               end
            end
         end
      end
   end

   always_comb begin
      mod_type = 3'b011;
      case ({state_reg == ACTIVE, is_tag})
         2'b00: mod_type = 3'b011;
         2'b10: mod_type = 3'b100;
         2'b01: mod_type = 3'b001;
         2'b11: mod_type = 3'b010;
         default: mod_type = 3'b011;
      endcase
   end

   assign frame_active = (state_reg == ACTIVE);
   assign bit_strobe   = strobe_reg;
   assign bit_out      = sr_reg[DELAY_TAP];
   assign frame_count  = fc_reg;
   assign timeout_err  = tout_reg;

endmodule

// File: tb/tb_relay_frame_detect.sv
// Bench for relay_frame_detect: directed test-plan scenarios plus random traffic,
// every clock compared against a queue-based behavioural model.
module tb_relay_frame_detect;

   localparam int FL   = 8;
   localparam int DIV  = 16;
   localparam int PH   = 8;
   localparam int MAXB = 32;
   localparam int TAP  = 7;
   localparam int RDS  = 'hc0;
   localparam int TGS  = 'hf0;
   localparam int RDA  = 'h0000;
   localparam int RDB  = 'hc000;
   localparam int TGE  = 'h0000;

   logic       clk = 1'b0;
   logic       rst, enable, is_tag, dbg;
   logic [2:0] mod_type;
   logic       frame_active, bit_strobe, bit_out, timeout_err;
   logic [7:0] frame_count;

   int n_checks = 0;
   int n_errors = 0;
   int n_strobes = 0;
   int n_touts = 0;

   // behavioural model state
   bit m_hist[$];
   bit m_sr[$];
   int m_div, m_bc, m_bt, m_fc;
   bit m_act, m_stb, m_tout;

   relay_frame_detect #(.MAX_BITS(MAXB)) dut (
      .ck_1356meg   (clk),
      .rst          (rst),
      .enable       (enable),
      .is_tag       (is_tag),
      .dbg          (dbg),
      .mod_type     (mod_type),
      .frame_active (frame_active),
      .bit_strobe   (bit_strobe),
      .bit_out      (bit_out),
      .frame_count  (frame_count),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear_sr();
      m_sr = {};
      repeat (24) m_sr.push_back(1'b0);
   endtask

   function automatic int win_value();
      int v = 0;
      foreach (m_sr[i]) v = (v << 1) | int'(m_sr[i]);
      return v;
   endfunction

   task automatic model_reset();
      m_hist = {};
      repeat (FL) m_hist.push_back(1'b0);
      model_clear_sr();
      m_div = 0; m_bc = 0; m_bt = 0; m_fc = 0;
      m_act = 0; m_stb = 0; m_tout = 0;
   endtask

   task automatic model_step();
      int  ones;
      bit  fb, stb, st, en;
      int  w, e;
      if (rst) begin
         model_reset();
         return;
      end
      ones = 0;
      foreach (m_hist[i]) ones += int'(m_hist[i]);
      fb  = (ones >= FL / 2);
      stb = enable && (m_div == PH);
      m_hist.push_back(dbg);
      void'(m_hist.pop_front());
      m_stb  = stb;
      m_tout = 0;
      if (!enable) begin
         m_div = 0; m_bc = 0; m_bt = 0; m_act = 0;
         model_clear_sr();
         return;
      end
      m_div = (m_div + 1) % DIV;
      if (!stb) return;
      m_sr.push_back(fb);
      void'(m_sr.pop_front());
      m_bc = (m_bc + 1) % 8;
      w  = win_value();
      e  = w / 256;
      st = (w == (is_tag ? TGS : RDS));
      en = (m_bc == 0) && (w % 256 == 0) && (is_tag ? (e == TGE) : (e == RDA || e == RDB));
      if (st) begin
         m_act = 1; m_bc = 0; m_bt = 0;
      end else if (m_act && en) begin
         m_act = 0; m_fc = (m_fc + 1) % 256;
      end else if (m_act && m_bt == MAXB - 1) begin
         m_act = 0; m_tout = 1;
      end else if (m_act) begin
         m_bt++;
      end
   endtask

   task automatic tick();
      int exp_mod, exp_vec, got_vec;
      @(posedge clk);
      model_step();
      #1;
      if (bit_strobe) n_strobes++;
      if (timeout_err) n_touts++;
      exp_mod = m_act ? (is_tag ? 2 : 4) : (is_tag ? 1 : 3);
      exp_vec = (exp_mod << 12) | (int'(m_act) << 11) | (int'(m_stb) << 10)
              | (int'(m_sr[23 - TAP]) << 9) | (m_fc << 1) | int'(m_tout);
      got_vec = {17'd0, mod_type, frame_active, bit_strobe, bit_out, frame_count, timeout_err};
      check("cycle", got_vec, exp_vec);
   endtask

   task automatic send_bit(input bit b, input bit glitch);
      int g;
      g = $urandom_range(1, DIV - 3);
      for (int c = 0; c < DIV; c++) begin
         dbg = (glitch && c >= g && c < g + 2) ? ~b : b;
         tick();
      end
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input bit glitch);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], glitch);
   endtask

   task automatic send_start(input bit glitch);
      send_bits(32'd0, 16, glitch);
      send_bits(is_tag ? TGS : RDS, 8, glitch);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int op, fc0;
      rst = 1; enable = 0; is_tag = 0; dbg = 0;
      model_reset();
      tick(); tick();
      check("rst_mod", mod_type, 3'b011);
      check("rst_fc", frame_count, 0);
      check("rst_act", frame_active, 0);
      check("rst_stb", bit_strobe, 0);
      rst = 0; enable = 1;

      // reader start
      send_bits(32'd0, 16, 0);
      send_bits(7'b1100000, 7, 0);
      check("rd_pre_mod", mod_type, 3'b011);
      send_bit(0, 0);
      check("rd_start_mod", mod_type, 3'b100);
      check("rd_start_act", frame_active, 1);
      $display("txn reader start: mod_type=%b", mod_type);

      // reader end on a byte boundary
      send_bits(8'haa, 8, 0);
      send_bits(8'hc0, 8, 0);
      send_bits(32'd0, 15, 0);
      check("rd_end_hold", frame_active, 1);
      send_bit(0, 0);
      check("rd_end_act", frame_active, 0);
      check("rd_end_mod", mod_type, 3'b011);
      check("rd_end_fc", frame_count, 1);
      $display("txn reader end: frame_count=%0d", frame_count);

      // misaligned end pattern
      send_start(0);
      send_bits(3'b101, 3, 0);
      send_bits(32'd0, 24, 0);
      check("mis_hold", frame_active, 1);
      send_bits(32'd0, 5, 0);
      check("mis_end_act", frame_active, 0);
      check("mis_end_fc", frame_count, 2);
      $display("txn misaligned end: frame_count=%0d", frame_count);

      // tag role with glitches
      is_tag = 1;
      tick();
      check("tag_idle_mod", mod_type, 3'b001);
      send_start(1);
      check("tag_start_mod", mod_type, 3'b010);
      send_bits(32'd0, 23, 1);
      check("tag_hold_mod", mod_type, 3'b010);
      send_bit(0, 1);
      check("tag_end_mod", mod_type, 3'b001);
      check("tag_end_fc", frame_count, 3);
      $display("txn tag frame: frame_count=%0d", frame_count);

      // timeout after MAXB strobes
      is_tag = 0;
      send_start(0);
      for (int i = 0; i < MAXB - 1; i++) send_bit(~i[0], 0);
      check("to_hold", frame_active, 1);
      n_touts = 0;
      send_bit(0, 0);
      check("to_act", frame_active, 0);
      check("to_pulse", n_touts, 1);
      check("to_fc", frame_count, 3);
      $display("txn timeout: pulses=%0d", n_touts);

      // enable drop mid-frame
      send_start(0);
      send_bits(5'b10110, 5, 0);
      enable = 0;
      n_strobes = 0;
      tick();
      check("en_act", frame_active, 0);
      check("en_mod", mod_type, 3'b011);
      repeat (40) tick();
      check("en_strobes", n_strobes, 0);
      check("en_fc", frame_count, 3);
      enable = 1;
      $display("txn enable drop: frame_count=%0d", frame_count);

      // reset mid-frame
      send_start(0);
      send_bits(4'b0011, 4, 0);
      rst = 1;
      tick();
      check("rs_mod", mod_type, 3'b011);
      check("rs_act", frame_active, 0);
      check("rs_fc", frame_count, 0);
      rst = 0;
      $display("txn reset mid-frame: frame_count=%0d", frame_count);

      // random traffic
      for (int k = 0; k < 40; k++) begin
         op  = $urandom_range(0, 4);
         fc0 = frame_count;
         case (op)
            0, 1: send_bits($urandom_range(0, 255), 8, 1'($urandom_range(0, 1)));
            2: send_start(1'($urandom_range(0, 1)));
            3: if (is_tag || $urandom_range(0, 1) == 0) send_bits(32'd0, 24, 0);
               else send_bits(RDB << 8, 24, 0);
            default: begin
               enable = 0;
               repeat ($urandom_range(1, 40)) tick();
               is_tag = 1'($urandom_range(0, 1));
               enable = 1;
            end
         endcase
         $display("txn random %0d op=%0d: frames %0d->%0d active=%0d", k, op, fc0, frame_count, frame_active);
      end

      // per-clock noise
      for (int k = 0; k < 300; k++) begin
         dbg = 1'($urandom_range(0, 1));
         tick();
      end
      $display("txn noise: frame_count=%0d", frame_count);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
